// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: frame sequencer for a byte-wide CRC-16 engine (generate mode appends {hi,lo}).
// Optional CRC_CHECK_EN adds a check mode that strips and verifies the trailing CRC bytes.
module crc_frame_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    input  logic        mode_chk,
    output logic [7:0]  crc_data_o,
    output logic        crc_en_o,
    output logic        crc_clr_o,
    input  logic [15:0] crc_val_i,
    output logic        chk_valid,
    output logic        chk_ok
);
    typedef enum logic [2:0] {IDLE, DATA, CRC_HI, CRC_LO, CHK} state_t;
    state_t     state_q;
    logic       m_valid_q, m_last_q, clr_q, load, acc;
    logic [7:0] m_data_q;
    assign load      = !m_valid_q || m_ready;
    assign s_ready   = (state_q == IDLE || state_q == DATA) && load;
    assign acc       = s_valid && s_ready;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    // clr_q covers the first cycle after reset release; the others close a frame
    assign crc_clr_o = clr_q || (state_q == CRC_LO && load) || state_q == CHK;
`ifdef CRC_CHECK_EN
    logic       mode_q, pay_q, chk_valid_q, chk_ok_q, chk_m;
    logic [1:0] cnt_q;
    logic [7:0] d0_q, d1_q;
    assign chk_m      = (state_q == IDLE) ? mode_chk : mode_q;
    assign crc_en_o   = acc && (!chk_m || cnt_q == 2'd2);
    assign crc_data_o = chk_m ? d0_q : s_data;
    assign chk_valid  = chk_valid_q;
    assign chk_ok     = chk_ok_q;
`else
    logic unused_mode;
    assign unused_mode = mode_chk;
    assign crc_en_o    = acc;
    assign crc_data_o  = s_data;
    assign chk_valid   = 1'b0;
    assign chk_ok      = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
            clr_q     <= 1'b1;
`ifdef CRC_CHECK_EN
            mode_q      <= 1'b0;
            pay_q       <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_ok_q    <= 1'b0;
            cnt_q       <= 2'd0;
            d0_q        <= 8'h00;
            d1_q        <= 8'h00;
`endif
        end else begin
            clr_q <= 1'b0;
            if (load) m_valid_q <= 1'b0;
`ifdef CRC_CHECK_EN
            chk_valid_q <= 1'b0;
`endif
            case (state_q)
                IDLE, DATA: if (acc) begin
`ifdef CRC_CHECK_EN
                    mode_q <= chk_m;
                    if (chk_m) begin
                        // only bytes leaving the 2-byte delay line are payload
                        if (cnt_q == 2'd2) begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= d0_q;
                            m_last_q  <= s_last;
                            d0_q      <= d1_q;
                            pay_q     <= 1'b1;
                        end else begin
                            if (cnt_q == 2'd0) d0_q <= s_data;
                            cnt_q <= cnt_q + 2'd1;
                        end
                        d1_q    <= s_data;
                        state_q <= s_last ? CHK : DATA;
                    end else
`endif
                    begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= s_data;
                        m_last_q  <= 1'b0;
                        state_q   <= s_last ? CRC_HI : DATA;
                    end
                end
                CRC_HI: if (load) begin
                    m_valid_q <= 1'b1;
                    m_data_q  <= crc_val_i[15:8];
                    m_last_q  <= 1'b0;
                    state_q   <= CRC_LO;
                end
                CRC_LO: if (load) begin
                    m_valid_q <= 1'b1;
                    m_data_q  <= crc_val_i[7:0];
                    m_last_q  <= 1'b1;
                    state_q   <= IDLE;
                end
`ifdef CRC_CHECK_EN
                CHK: begin
                    chk_valid_q <= 1'b1;
                    chk_ok_q    <= pay_q && crc_val_i == {d0_q, d1_q};
                    cnt_q       <= 2'd0;
                    pay_q       <= 1'b0;
                    state_q     <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb_crc_frame_ctrl: table vectors, corner sequences and random frames for crc_frame_ctrl.
// The engine is a bench model (CRC-16 poly 0x8005, preset 0xFFFF) that can be overridden by a stub.
module tb_crc_frame_ctrl;
    typedef struct {
        int          len;
        logic [31:0] b;
        logic        chk;
        logic [15:0] stub;
        int          n_out;
        logic [53:0] o;
        logic        cv;
        logic        ok;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1, mode_chk = 1'b0;
    logic        s_ready, m_valid, m_last, crc_en_o, crc_clr_o, chk_valid, chk_ok;
    logic [7:0]  s_data = 8'h00, m_data, crc_data_o;
    logic [15:0] crc_val_i, eng_q = 16'hFFFF, stub_val = 16'h0000;
    logic        stub_en = 1'b0;
    int          n_chk = 0, n_fail = 0, en_cnt = 0, clr_cnt = 0, rdy_mode = 0;
    logic [8:0]  out_q[$];
    logic        chk_q[$];
    logic [8:0]  prev_out = 9'h000;
    logic        prev_stall = 1'b0;
    vec_t        vt[$];

    always #5 clk = ~clk;

    crc_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .mode_chk(mode_chk), .crc_data_o(crc_data_o), .crc_en_o(crc_en_o), .crc_clr_o(crc_clr_o),
        .crc_val_i(crc_val_i), .chk_valid(chk_valid), .chk_ok(chk_ok)
    );

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h8005) : {r[14:0], 1'b0};
        return r;
    endfunction

    assign crc_val_i = stub_en ? stub_val : eng_q;

    always @(posedge clk)
        if (crc_clr_o) eng_q <= 16'hFFFF;
        else if (crc_en_o) eng_q <= crc_byte(eng_q, crc_data_o);

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (prev_stall && rst_n) check("hold_stable", {m_valid, m_last, m_data}, {1'b1, prev_out});
        prev_stall = rst_n && m_valid && !m_ready;
        prev_out   = {m_last, m_data};
        if (m_valid && m_ready) out_q.push_back({m_last, m_data});
        if (crc_en_o) en_cnt++;
        if (crc_clr_o) clr_cnt++;
        if (chk_valid) chk_q.push_back(chk_ok);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input logic m, input int gap);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = l; mode_chk = m;
        do begin @(negedge clk); n++; end while (!s_ready && n < 300);
        check("s_ready", s_ready, 1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (out_q.size() < n && t < 1000) begin @(negedge clk); t++; end
        if (out_q.size() < n) check("out_timeout", out_q.size(), n);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cmp_out(input string name, input logic [8:0] exp[$]);
        check({name, "_count"}, out_q.size(), exp.size());
        for (int j = 0; j < exp.size() && j < out_q.size(); j++) check(name, out_q[j], exp[j]);
    endtask

    task automatic run_vec(input vec_t v);
        logic [8:0] exp[$];
        out_q.delete(); chk_q.delete(); en_cnt = 0;
        stub_en = 1'b1; stub_val = v.stub;
        for (int i = 0; i < v.len; i++) send_byte(v.b[31-8*i -: 8], i == v.len - 1, v.chk, 0);
        wait_out(v.n_out);
        for (int j = 0; j < v.n_out; j++) exp.push_back(v.o[53-9*j -: 9]);
        cmp_out("vec_out", exp);
        check("vec_crc_en", en_cnt, v.chk ? (v.len > 2 ? v.len - 2 : 0) : v.len);
        check("vec_chk_valid", chk_q.size(), v.cv ? 1 : 0);
        if (v.cv && chk_q.size() > 0) check("vec_chk_ok", chk_q[0], v.ok);
    endtask

    task automatic rand_frames(input logic chk, input int nf);
        logic [7:0]  fr[$];
        logic [8:0]  exp[$];
        logic [15:0] c;
        logic        exp_ok;
        int          pl, idx;
        for (int f = 0; f < nf; f++) begin
            fr.delete(); exp.delete(); out_q.delete(); chk_q.delete();
            c = 16'hFFFF; exp_ok = 1'b0;
            if (!chk) begin
                pl = $urandom_range(1, 8);
                for (int i = 0; i < pl; i++) fr.push_back(8'($urandom));
                foreach (fr[i]) begin exp.push_back({1'b0, fr[i]}); c = crc_byte(c, fr[i]); end
                exp.push_back({1'b0, c[15:8]});
                exp.push_back({1'b1, c[7:0]});
            end else begin
                pl = $urandom_range(0, 6);
                for (int i = 0; i < pl; i++) begin fr.push_back(8'($urandom)); c = crc_byte(c, fr[i]); end
                fr.push_back(c[15:8]);
                fr.push_back(c[7:0]);
                if ($urandom_range(0, 2) == 0) begin
                    idx = $urandom_range(0, fr.size() - 1);
                    fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(0, 7));
                end
                // expectation from the framing rule: trailing two bytes are the CRC of the rest
                if (fr.size() >= 3) begin
                    c = 16'hFFFF;
                    for (int i = 0; i < fr.size() - 2; i++) begin
                        exp.push_back({(i == fr.size() - 3), fr[i]});
                        c = crc_byte(c, fr[i]);
                    end
                    exp_ok = (c == {fr[fr.size()-2], fr[fr.size()-1]});
                end
            end
            foreach (fr[i]) send_byte(fr[i], i == fr.size() - 1, chk, $urandom_range(0, 2));
            wait_out(exp.size());
            cmp_out(chk ? "rnd_chk_out" : "rnd_gen_out", exp);
            check("rnd_chk_valid", chk_q.size(), chk ? 1 : 0);
            if (chk && chk_q.size() > 0) check("rnd_chk_ok", chk_q[0], exp_ok);
        end
    endtask

    initial begin
        logic [8:0] e[$];
        vt.push_back('{3, 32'h01020300, 1'b0, 16'hBEEF, 5,
                       {9'h001, 9'h002, 9'h003, 9'h0BE, 9'h1EF, 9'h000}, 1'b0, 1'b0});
        vt.push_back('{1, 32'h5A000000, 1'b0, 16'h1234, 3,
                       {9'h05A, 9'h012, 9'h134, 27'h0}, 1'b0, 1'b0});
        vt.push_back('{2, 32'hFF000000, 1'b0, 16'h0000, 4,
                       {9'h0FF, 9'h000, 9'h000, 9'h100, 18'h0}, 1'b0, 1'b0});
        vt.push_back('{4, 32'h807FC33C, 1'b0, 16'hA55A, 6,
                       {9'h080, 9'h07F, 9'h0C3, 9'h03C, 9'h0A5, 9'h15A}, 1'b0, 1'b0});
`ifdef CRC_CHECK_EN
        vt.push_back('{4, 32'hAABB1234, 1'b1, 16'h1234, 2, {9'h0AA, 9'h1BB, 36'h0}, 1'b1, 1'b1});
        vt.push_back('{4, 32'hAABB1234, 1'b1, 16'h1235, 2, {9'h0AA, 9'h1BB, 36'h0}, 1'b1, 1'b0});
        vt.push_back('{2, 32'h12340000, 1'b1, 16'h1234, 0, 54'h0, 1'b1, 1'b0});
        vt.push_back('{3, 32'h01123400, 1'b1, 16'h1234, 1, {9'h101, 45'h0}, 1'b1, 1'b1});
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_chk_valid", chk_valid, 0);
        check("rst_m_data_last", {m_last, m_data}, 0);
        check("rst_crc_en", crc_en_o, 0);
        rst_n = 1'b1; clr_cnt = 0;
        repeat (4) @(posedge clk);
        #1;
        check("clr_after_rst", clr_cnt, 1);

        for (int rm = 0; rm < 2; rm++) begin
            rdy_mode = rm;
            foreach (vt[i]) run_vec(vt[i]);
        end

        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        out_q.delete(); clr_cnt = 0; stub_en = 1'b1; stub_val = 16'h1234;
        send_byte(8'h5A, 1'b1, 1'b0, 0);
        send_byte(8'h77, 1'b1, 1'b0, 0);
        wait_out(6);
        e = '{9'h05A, 9'h012, 9'h134, 9'h077, 9'h012, 9'h134};
        cmp_out("b2b_out", e);
        check("b2b_clr", clr_cnt, 2);

        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        out_q.delete(); stub_val = 16'hDEAD;
        send_byte(8'h11, 1'b1, 1'b0, 0);
        @(posedge clk);
        #1;
        check("stall_m_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_hi_m_valid", m_valid, 0);
        check("rst_hi_no_out", out_q.size(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; clr_cnt = 0; rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_hi_clr", clr_cnt, 1);
        out_q.delete(); stub_val = 16'h4321;
        send_byte(8'h22, 1'b1, 1'b0, 0);
        wait_out(3);
        e = '{9'h022, 9'h043, 9'h121};
        cmp_out("after_rst_out", e);

        rdy_mode = 2; stub_en = 1'b0;
        rand_frames(1'b0, 30);
`ifdef CRC_CHECK_EN
        rand_frames(1'b1, 30);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
